// File: rtl/axi_data_responder.sv
// AXI-4 responder backed by an internal word array; one transaction at a time, shared R/W FSM.
// Latency: first R beat one cycle after AR handshake, then one beat/cycle; B one cycle after last W beat.
// Backpressure: R/B held stable while rready/bready low; AR/AW readied only in IDLE with alternating priority.
// Optional build macro WAIT_STATE_INJECT_EN: stalls rvalid/wready whenever a free-running 2-bit counter equals 3.
module axi_data_responder #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_AW     = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   arid_s_inf,
  input  logic [ADDR_WIDTH-1:0] araddr_s_inf,
  input  logic [7:0]            arlen_s_inf,
  input  logic [2:0]            arsize_s_inf,
  input  logic [1:0]            arburst_s_inf,
  input  logic                  arvalid_s_inf,
  output logic                  arready_s_inf,
  output logic [ID_WIDTH-1:0]   rid_s_inf,
  output logic [DATA_WIDTH-1:0] rdata_s_inf,
  output logic [1:0]            rresp_s_inf,
  output logic                  rlast_s_inf,
  output logic                  rvalid_s_inf,
  input  logic                  rready_s_inf,
  input  logic [ID_WIDTH-1:0]   awid_s_inf,
  input  logic [ADDR_WIDTH-1:0] awaddr_s_inf,
  input  logic [7:0]            awlen_s_inf,
  input  logic [2:0]            awsize_s_inf,
  input  logic [1:0]            awburst_s_inf,
  input  logic                  awvalid_s_inf,
  output logic                  awready_s_inf,
  input  logic [DATA_WIDTH-1:0] wdata_s_inf,
  input  logic                  wlast_s_inf,
  input  logic                  wvalid_s_inf,
  output logic                  wready_s_inf,
  output logic [ID_WIDTH-1:0]   bid_s_inf,
  output logic [1:0]            bresp_s_inf,
  output logic                  bvalid_s_inf,
  input  logic                  bready_s_inf
);

  localparam int         SHIFT   = $clog2(DATA_WIDTH / 8);
  localparam logic [2:0] SIZE_OK = 3'(SHIFT);
  localparam logic [1:0] OKAY    = 2'b00;
  localparam logic [1:0] SLVERR  = 2'b10;

  typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

  state_t                state_q, state_d;
  logic                  ptr_q, ptr_d;        // 1: write channel favoured
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [MEM_AW-1:0]     idx_q, idx_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  fixed_q, fixed_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rlast_q, rlast_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [1:0]            bresp_q, bresp_d;

  logic [DATA_WIDTH-1:0] mem_q [2**MEM_AW];
  logic                  mem_we;
  logic [MEM_AW-1:0]     mem_waddr;

  logic                  stall;
  logic                  ar_hs, aw_hs, r_hs, w_hs;
  logic [MEM_AW-1:0]     ar_idx, aw_idx, next_idx;
  logic                  ar_err, aw_err, beat_last, wlast_bad;
  logic                  unused_addr_bits;

`ifdef WAIT_STATE_INJECT_EN
  logic [1:0] wait_cnt_q, wait_cnt_d;

  // Free-running stall pacer
  always_comb wait_cnt_d = wait_cnt_q + 2'd1;

  // Stall pacer register
  always_ff @(posedge clk) begin
    if (rst) wait_cnt_q <= 2'd0;
    else     wait_cnt_q <= wait_cnt_d;
  end

  assign stall = (wait_cnt_q == 2'd3);
`else
  assign stall = 1'b0;
`endif

  // Byte address to word index; bits above the array and below a word are ignored
  assign ar_idx = araddr_s_inf[SHIFT +: MEM_AW];
  assign aw_idx = awaddr_s_inf[SHIFT +: MEM_AW];
  assign unused_addr_bits = ^{araddr_s_inf[ADDR_WIDTH-1:SHIFT+MEM_AW], araddr_s_inf[SHIFT-1:0],
                              awaddr_s_inf[ADDR_WIDTH-1:SHIFT+MEM_AW], awaddr_s_inf[SHIFT-1:0]};

  // WRAP and reserved bursts, and any size other than one full word, are answered with SLVERR
  assign ar_err = arburst_s_inf[1] || (arsize_s_inf != SIZE_OK);
  assign aw_err = awburst_s_inf[1] || (awsize_s_inf != SIZE_OK);

  // Readies are suppressed while reset is held so no handshake can complete during it
  assign arready_s_inf = !rst && (state_q == IDLE) && (!ptr_q || !awvalid_s_inf);
  assign awready_s_inf = !rst && (state_q == IDLE) && ( ptr_q || !arvalid_s_inf);
  assign rvalid_s_inf  = (state_q == RD) && !stall;
  assign wready_s_inf  = (state_q == WR) && !stall;
  assign bvalid_s_inf  = (state_q == WRESP);
  assign rid_s_inf     = rid_q;
  assign rdata_s_inf   = rdata_q;
  assign rresp_s_inf   = rresp_q;
  assign rlast_s_inf   = rlast_q;
  assign bid_s_inf     = bid_q;
  assign bresp_s_inf   = bresp_q;

  assign ar_hs = arvalid_s_inf && arready_s_inf;
  assign aw_hs = awvalid_s_inf && awready_s_inf;
  assign r_hs  = rvalid_s_inf && rready_s_inf;
  assign w_hs  = wvalid_s_inf && wready_s_inf;

  assign beat_last = (cnt_q == len_q);
  assign wlast_bad = (wlast_s_inf != beat_last);
  assign next_idx  = fixed_q ? idx_q : idx_q + 1'b1;  // INCR wraps modulo the array depth

  // Next-state and datapath for the shared read/write FSM
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rid_d     = rid_q;
    bid_d     = bid_q;
    idx_d     = idx_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    fixed_d   = fixed_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    mem_waddr = idx_q;

    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          state_d = WR;
          ptr_d   = ~ptr_q;
          bid_d   = awid_s_inf;
          idx_d   = aw_idx;
          len_d   = awlen_s_inf;
          cnt_d   = 8'd0;
          fixed_d = (awburst_s_inf == 2'b00);
          err_d   = aw_err;
        end else if (ar_hs) begin
          state_d = RD;
          ptr_d   = ~ptr_q;
          rid_d   = arid_s_inf;
          idx_d   = ar_idx;
          len_d   = arlen_s_inf;
          cnt_d   = 8'd0;
          fixed_d = (arburst_s_inf == 2'b00);
          err_d   = ar_err;
          rdata_d = mem_q[ar_idx];
          rlast_d = (arlen_s_inf == 8'd0);
          rresp_d = ar_err ? SLVERR : OKAY;
        end
      end
      RD: begin
        if (r_hs) begin
          if (beat_last) begin
            state_d = IDLE;
            rlast_d = 1'b0;
          end else begin
            // Prefetch the next word on the same edge so beats can run back to back
            cnt_d   = cnt_q + 8'd1;
            idx_d   = next_idx;
            rdata_d = mem_q[next_idx];
            rlast_d = ((cnt_q + 8'd1) == len_q);
          end
        end
      end
      WR: begin
        if (w_hs) begin
          mem_we = !rst;
          err_d  = err_q || wlast_bad;
          if (beat_last) begin
            state_d = WRESP;
            bresp_d = (err_q || wlast_bad) ? SLVERR : OKAY;
          end else begin
            cnt_d = cnt_q + 8'd1;
            idx_d = next_idx;
          end
        end
      end
      WRESP: begin
        if (bready_s_inf) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers; reset aborts any burst without a response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b1;
      rid_q   <= '0;
      bid_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      fixed_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rlast_q <= 1'b0;
      rresp_q <= OKAY;
      bresp_q <= OKAY;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rid_q   <= rid_d;
      bid_q   <= bid_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      fixed_q <= fixed_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      rlast_q <= rlast_d;
      rresp_q <= rresp_d;
      bresp_q <= bresp_d;
    end
  end

  // Array write port; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= wdata_s_inf;
  end

endmodule

// File: tb/tb_axi_data_responder.sv
// Directed bench for axi_data_responder: reset, priority, bursts, wrap, errors, stalls, mid-burst reset.
// Inputs driven 1 time unit after the rising edge; outputs sampled on the falling edge.
// Every wait on the DUT is bounded; an expired bound is reported as a failed comparison.
module tb_axi_data_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  arid_s_inf, rid_s_inf, awid_s_inf, bid_s_inf;
  logic [31:0] araddr_s_inf, awaddr_s_inf;
  logic [7:0]  arlen_s_inf, awlen_s_inf;
  logic [2:0]  arsize_s_inf, awsize_s_inf;
  logic [1:0]  arburst_s_inf, awburst_s_inf, rresp_s_inf, bresp_s_inf;
  logic        arvalid_s_inf, arready_s_inf, rlast_s_inf, rvalid_s_inf, rready_s_inf;
  logic        awvalid_s_inf, awready_s_inf, wlast_s_inf, wvalid_s_inf, wready_s_inf;
  logic        bvalid_s_inf, bready_s_inf;
  logic [15:0] rdata_s_inf, wdata_s_inf;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] wd [0:7];
  logic [15:0] ed [0:7];

  always #5 clk = ~clk;

  axi_data_responder dut (
    .clk(clk), .rst(rst),
    .arid_s_inf(arid_s_inf), .araddr_s_inf(araddr_s_inf), .arlen_s_inf(arlen_s_inf),
    .arsize_s_inf(arsize_s_inf), .arburst_s_inf(arburst_s_inf), .arvalid_s_inf(arvalid_s_inf),
    .arready_s_inf(arready_s_inf), .rid_s_inf(rid_s_inf), .rdata_s_inf(rdata_s_inf),
    .rresp_s_inf(rresp_s_inf), .rlast_s_inf(rlast_s_inf), .rvalid_s_inf(rvalid_s_inf),
    .rready_s_inf(rready_s_inf), .awid_s_inf(awid_s_inf), .awaddr_s_inf(awaddr_s_inf),
    .awlen_s_inf(awlen_s_inf), .awsize_s_inf(awsize_s_inf), .awburst_s_inf(awburst_s_inf),
    .awvalid_s_inf(awvalid_s_inf), .awready_s_inf(awready_s_inf), .wdata_s_inf(wdata_s_inf),
    .wlast_s_inf(wlast_s_inf), .wvalid_s_inf(wvalid_s_inf), .wready_s_inf(wready_s_inf),
    .bid_s_inf(bid_s_inf), .bresp_s_inf(bresp_s_inf), .bvalid_s_inf(bvalid_s_inf),
    .bready_s_inf(bready_s_inf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ar_req(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    bit got = 1'b0;
    arid_s_inf = id; araddr_s_inf = addr; arlen_s_inf = len;
    arsize_s_inf = size; arburst_s_inf = burst; arvalid_s_inf = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (arready_s_inf) got = 1'b1;
      step();
    end
    arvalid_s_inf = 1'b0;
    chk("ar_accept", 32'(got), 32'd1);
  endtask

  task automatic aw_req(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [1:0] burst);
    bit got = 1'b0;
    awid_s_inf = id; awaddr_s_inf = addr; awlen_s_inf = len;
    awsize_s_inf = 3'd1; awburst_s_inf = burst; awvalid_s_inf = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (awready_s_inf) got = 1'b1;
      step();
    end
    awvalid_s_inf = 1'b0;
    chk("aw_accept", 32'(got), 32'd1);
  endtask

  // Full write burst from wd[], beats back to back; early=1 drives wlast on every beat
  task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input bit early, input logic [1:0] exp_resp);
    aw_req(id, addr, 8'(len), 2'b01);
    for (int i = 0; i <= len; i++) begin
      wvalid_s_inf = 1'b1;
      wdata_s_inf  = wd[i];
      wlast_s_inf  = early ? 1'b1 : (i == len);
      @(negedge clk);
      chk($sformatf("wready_%0d", i), 32'(wready_s_inf), 32'd1);
      step();
    end
    wvalid_s_inf = 1'b0; wlast_s_inf = 1'b0; bready_s_inf = 1'b1;
    @(negedge clk);
    chk("bvalid", 32'(bvalid_s_inf), 32'd1);
    chk("bid", 32'(bid_s_inf), 32'(id));
    chk("bresp", 32'(bresp_s_inf), 32'(exp_resp));
    step();
    bready_s_inf = 1'b0;
  endtask

  // Consume a read burst with rready held high, expecting one beat per cycle
  task automatic rd_check(input int len, input logic [3:0] id, input logic [1:0] exp_resp,
                          input bit chk_data);
    rready_s_inf = 1'b1;
    for (int i = 0; i <= len; i++) begin
      @(negedge clk);
      chk($sformatf("rvalid_%0d", i), 32'(rvalid_s_inf), 32'd1);
      if (chk_data) chk($sformatf("rdata_%0d", i), 32'(rdata_s_inf), 32'(ed[i]));
      chk($sformatf("rlast_%0d", i), 32'(rlast_s_inf), 32'(i == len));
      chk("rid", 32'(rid_s_inf), 32'(id));
      chk("rresp", 32'(rresp_s_inf), 32'(exp_resp));
      step();
    end
    rready_s_inf = 1'b0;
    @(negedge clk);
    chk("rvalid_done", 32'(rvalid_s_inf), 32'd0);
    chk("arready_idle", 32'(arready_s_inf), 32'd1);
    step();
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_arready"}, 32'(arready_s_inf), 32'd0);
    chk({pfx, "_awready"}, 32'(awready_s_inf), 32'd0);
    chk({pfx, "_rvalid"},  32'(rvalid_s_inf),  32'd0);
    chk({pfx, "_wready"},  32'(wready_s_inf),  32'd0);
    chk({pfx, "_bvalid"},  32'(bvalid_s_inf),  32'd0);
    chk({pfx, "_rdata"},   32'(rdata_s_inf),   32'd0);
    chk({pfx, "_rresp"},   32'(rresp_s_inf),   32'd0);
    chk({pfx, "_rlast"},   32'(rlast_s_inf),   32'd0);
    chk({pfx, "_rid"},     32'(rid_s_inf),     32'd0);
    chk({pfx, "_bid"},     32'(bid_s_inf),     32'd0);
    chk({pfx, "_bresp"},   32'(bresp_s_inf),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    arid_s_inf = '0; araddr_s_inf = '0; arlen_s_inf = '0; arsize_s_inf = '0; arburst_s_inf = '0;
    arvalid_s_inf = 1'b0; rready_s_inf = 1'b0;
    awid_s_inf = '0; awaddr_s_inf = '0; awlen_s_inf = '0; awsize_s_inf = '0; awburst_s_inf = '0;
    awvalid_s_inf = 1'b0; wdata_s_inf = '0; wlast_s_inf = 1'b0; wvalid_s_inf = 1'b0;
    bready_s_inf = 1'b0;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    chk_reset_outputs("rst");
    step();
    rst = 1'b0;

    // AR and AW together right after reset: write is favoured
    awid_s_inf = 4'd5; awaddr_s_inf = 32'h10; awlen_s_inf = 8'd3; awsize_s_inf = 3'd1;
    awburst_s_inf = 2'b01; awvalid_s_inf = 1'b1;
    arid_s_inf = 4'd2; araddr_s_inf = 32'h10; arlen_s_inf = 8'd3; arsize_s_inf = 3'd1;
    arburst_s_inf = 2'b01; arvalid_s_inf = 1'b1;
    @(negedge clk);
    chk("both_awready", 32'(awready_s_inf), 32'd1);
    chk("both_arready", 32'(arready_s_inf), 32'd0);
    step();
    awvalid_s_inf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wvalid_s_inf = 1'b1;
      wdata_s_inf  = 16'(32'hA0 + i);
      wlast_s_inf  = (i == 3);
      @(negedge clk);
      chk($sformatf("w1_wready_%0d", i), 32'(wready_s_inf), 32'd1);
      chk($sformatf("w1_arready_busy_%0d", i), 32'(arready_s_inf), 32'd0);
      step();
    end
    wvalid_s_inf = 1'b0; wlast_s_inf = 1'b0; bready_s_inf = 1'b1;
    @(negedge clk);
    chk("w1_bvalid", 32'(bvalid_s_inf), 32'd1);
    chk("w1_bid", 32'(bid_s_inf), 32'd5);
    chk("w1_bresp", 32'(bresp_s_inf), 32'd0);
    chk("w1_wready_off", 32'(wready_s_inf), 32'd0);
    step();
    bready_s_inf = 1'b0;
    @(negedge clk);
    chk("ar_after_b", 32'(arready_s_inf), 32'd1);
    chk("b_dropped", 32'(bvalid_s_inf), 32'd0);
    step();
    arvalid_s_inf = 1'b0;
    ed[0] = 16'hA0; ed[1] = 16'hA1; ed[2] = 16'hA2; ed[3] = 16'hA3;
    rd_check(3, 4'd2, 2'b00, 1'b1);

    // Write and read across the top of the array (word 0x1FFF then word 0)
    wd[0] = 16'h1234; wd[1] = 16'h5678;
    wr_burst(4'd3, 32'h3FFE, 1, 1'b0, 2'b00);
    ar_req(4'd1, 32'h3FFE, 8'd1, 3'd1, 2'b01);
    ed[0] = 16'h1234; ed[1] = 16'h5678;
    rd_check(1, 4'd1, 2'b00, 1'b1);

    // Early wlast: both beats still stored, SLVERR in B
    wd[0] = 16'hBEE0; wd[1] = 16'hBEE1;
    wr_burst(4'd7, 32'h40, 1, 1'b1, 2'b10);
    ar_req(4'd8, 32'h40, 8'd1, 3'd1, 2'b01);
    ed[0] = 16'hBEE0; ed[1] = 16'hBEE1;
    rd_check(1, 4'd8, 2'b00, 1'b1);

    // WRAP burst read: every beat SLVERR
    ar_req(4'd9, 32'h40, 8'd1, 3'd1, 2'b10);
    rd_check(1, 4'd9, 2'b10, 1'b0);

    // FIXED burst read: address stays on word 8
    ar_req(4'd10, 32'h10, 8'd2, 3'd1, 2'b00);
    ed[0] = 16'hA0; ed[1] = 16'hA0; ed[2] = 16'hA0;
    rd_check(2, 4'd10, 2'b00, 1'b1);

    // len=0: single beat carrying rlast
    ar_req(4'd11, 32'h12, 8'd0, 3'd1, 2'b01);
    ed[0] = 16'hA1;
    rd_check(0, 4'd11, 2'b00, 1'b1);

    // Wrong beat size: SLVERR
    ar_req(4'd12, 32'h10, 8'd0, 3'd0, 2'b01);
    ed[0] = 16'hA0;
    rd_check(0, 4'd12, 2'b10, 1'b1);

    // rready toggling then reset mid-burst
    ar_req(4'd4, 32'h10, 8'd2, 3'd1, 2'b01);
    rready_s_inf = 1'b0;
    @(negedge clk);
    chk("stall_rvalid", 32'(rvalid_s_inf), 32'd1);
    chk("stall_rdata0", 32'(rdata_s_inf), 32'hA0);
    chk("stall_rlast0", 32'(rlast_s_inf), 32'd0);
    step();
    rready_s_inf = 1'b1;
    @(negedge clk);
    chk("stall_rdata0_held", 32'(rdata_s_inf), 32'hA0);
    step();
    rready_s_inf = 1'b0;
    @(negedge clk);
    chk("stall_rdata1", 32'(rdata_s_inf), 32'hA1);
    chk("stall_rlast1", 32'(rlast_s_inf), 32'd0);
    step();
    @(negedge clk);
    chk("stall_rdata1_held", 32'(rdata_s_inf), 32'hA1);
    chk("stall_rvalid_held", 32'(rvalid_s_inf), 32'd1);
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk_reset_outputs("midrst");
    step();
    rst = 1'b0;
    ar_req(4'd6, 32'h14, 8'd0, 3'd1, 2'b01);
    ed[0] = 16'hA2;
    rd_check(0, 4'd6, 2'b00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
